muldiv_sequencer: RTL and testbench

//  Multi-cycle MULTU/DIVU engine plus architectural HI/LO registers for the MIPS core.

---
 rtl/muldiv_sequencer.sv | 135 +++++++++++++
 tb/tb_muldiv_sequencer.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned MULTU/DIVU engine with the architectural HI/LO registers.
// One result bit per clock; the pipeline is stalled while HI/LO are not yet valid.
module muldiv_sequencer #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             flush,
  input  logic             rd_req,
  output logic             busy,
  output logic             done,
  output logic             stall,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [3:0] MULTU_AC = 4'd7;
  localparam logic [3:0] DIVU_AC  = 4'd8;

  typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  // opa: multiplicand / dividend (shifted left); opb: multiplier (shifted right) / divisor
  logic [WIDTH-1:0]     opa_q, opa_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 done_q, done_d;

  logic [WIDTH:0]       mul_sum;
  logic [WIDTH:0]       rem_sh;
  logic [WIDTH+1:0]     trial;
  logic                 trial_ok;
  logic [2*WIDTH-1:0]   step_acc;
  logic                 is_muldiv_op;

  assign is_muldiv_op = (op == MULTU_AC) || (op == DIVU_AC);

  // Multiply step: add multiplicand into the upper half, keeping the carry for the shift.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
  // Divide step: extra guard bit so the trial sign is exact even when rem_sh >= 2^WIDTH.
  assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], opa_q[WIDTH-1]};
  assign trial    = {1'b0, rem_sh} - {2'b00, opb_q};
  assign trial_ok = ~trial[WIDTH+1];

  always_comb begin
    step_acc = acc_q;
    if (state_q == MUL) begin
      step_acc = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (state_q == DIV) begin
      step_acc = {(trial_ok ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0]),
                  acc_q[WIDTH-2:0], trial_ok};
    end
  end

  // NOTE: every _d gets a default first so no path through this block can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start && !flush && is_muldiv_op) begin
          state_d = (op == MULTU_AC) ? MUL : DIV;
          opa_d   = src_a;
          opb_d   = src_b;
          acc_d   = '0;
          cnt_d   = CNT_W'(WIDTH - 1);
        end
      end
      MUL, DIV: begin
        if (flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          acc_d = step_acc;
          if (state_q == MUL) opb_d = opb_q >> 1;
          else                opa_d = opa_q << 1;
          if (cnt_q == '0) begin
            state_d = IDLE;
            hi_d    = step_acc[2*WIDTH-1:WIDTH];
            lo_d    = step_acc[WIDTH-1:0];
            done_d  = 1'b1;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      opa_q   <= '0;
      opb_q   <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
    end
  end

  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;
  assign stall = busy && (rd_req || (start && is_muldiv_op));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Directed bench for muldiv_sequencer: multiply/divide results, timing, stall, flush and reset.
module tb_muldiv_sequencer;

  localparam int W = 32;
  localparam logic [3:0] MULTU_AC = 4'd7;
  localparam logic [3:0] DIVU_AC  = 4'd8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [3:0]    op;
  logic [W-1:0]  src_a, src_b;
  logic          flush, rd_req;
  logic          busy, done, stall;
  logic [W-1:0]  hi, lo;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .flush  (flush),
    .rd_req (rd_req),
    .busy   (busy),
    .done   (done),
    .stall  (stall),
    .hi     (hi),
    .lo     (lo)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Launch one operation, count busy cycles and check the committed result.
  task automatic run_op(input string tag, input logic [3:0] o, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    @(negedge clk);
    start = 1'b1; op = o; src_a = a; src_b = b;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'd32);
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_hi"}, 64'(hi), 64'(eh));
    check({tag, "_lo"}, 64'(lo), 64'(el));
    @(negedge clk);
    check({tag, "_done_one_cycle"}, 64'(done), 64'd0);
  endtask

  initial begin
    bit saw_done;
    reset_n = 1'b0; start = 1'b0; op = 4'd0; src_a = '0; src_b = '0;
    flush = 1'b0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    reset_n = 1'b1;

    run_op("mul_6x7", MULTU_AC, 32'd6, 32'd7, 32'h0, 32'h2A);
    run_op("mul_max", MULTU_AC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h1);
    run_op("div_100_7", DIVU_AC, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_5_0", DIVU_AC, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);

    // Unrelated op code: no launch, no stall, HI/LO untouched.
    @(negedge clk);
    start = 1'b1; op = 4'd3; rd_req = 1'b1;
    #1 check("ign_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; rd_req = 1'b0;
    check("ign_busy", 64'(busy), 64'd0);
    check("ign_hi", 64'(hi), 64'd5);

    // flush together with start in IDLE blocks the launch.
    @(negedge clk);
    start = 1'b1; op = MULTU_AC; src_a = 32'd2; src_b = 32'd2; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("idle_flush_busy", 64'(busy), 64'd0);

    // A new launch request during busy stalls only for multiply/divide codes.
    @(negedge clk);
    start = 1'b1; op = MULTU_AC; src_a = 32'd6; src_b = 32'd7;
    @(negedge clk);
    op = DIVU_AC; src_a = 32'd1; src_b = 32'd1;
    #1 check("busy_start_stall", 64'(stall), 64'd1);
    op = 4'd2;
    #1 check("busy_other_nostall", 64'(stall), 64'd0);
    start = 1'b0; op = 4'd0;
    for (int i = 0; i < 40 && busy; i++) @(negedge clk);
    check("busy_start_lo", 64'(lo), 64'h2A);
    @(negedge clk);
    check("stalled_start_not_queued", 64'(busy), 64'd0);

    // rd_req held through the operation: stall tracks busy, drops in the done cycle.
    @(negedge clk);
    start = 1'b1; op = MULTU_AC; src_a = 32'd6; src_b = 32'd7;
    #1 check("rd_launch_stall", 64'(stall), 64'd0);
    @(negedge clk);
    start = 1'b0; op = 4'd0; rd_req = 1'b1;
    for (int i = 0; i < 40; i++) begin
      #1;
      check($sformatf("rd_stall_%0d", i), 64'(stall), 64'(i < 32));
      check($sformatf("rd_done_%0d", i), 64'(done), 64'(i == 32));
      @(negedge clk);
    end
    rd_req = 1'b0;
    check("rd_hi", 64'(hi), 64'h0);
    check("rd_lo", 64'(lo), 64'h2A);

    // Abort a divide on its 10th busy cycle: no done, HI/LO kept.
    @(negedge clk);
    start = 1'b1; op = DIVU_AC; src_a = 32'd9; src_b = 32'd2;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_done", 64'(done), 64'd0);
    check("flush_hi", 64'(hi), 64'h0);
    check("flush_lo", 64'(lo), 64'h2A);
    saw_done = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("flush_no_late_done", 64'(saw_done), 64'd0);

    // Async reset in the middle of a divide.
    @(negedge clk);
    start = 1'b1; op = DIVU_AC; src_a = 32'd100; src_b = 32'd7; rd_req = 1'b1;
    @(negedge clk);
    start = 1'b0; op = 4'd0;
    repeat (14) @(negedge clk);
    check("mid_rst_busy_before", 64'(busy), 64'd1);
    check("mid_rst_stall_before", 64'(stall), 64'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_stall", 64'(stall), 64'd0);
    check("mid_rst_done", 64'(done), 64'd0);
    check("mid_rst_hi", 64'(hi), 64'd0);
    check("mid_rst_lo", 64'(lo), 64'd0);
    rd_req = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    run_op("mul_3x3", MULTU_AC, 32'd3, 32'd3, 32'd0, 32'd9);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
